// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: busy indications, decode/execute
// hazard info and redirect requests in; per-stage hold/bubble controls and PC redirect out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 64
);
    logic             if_busy;
    logic             mem_busy;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_dst;
    logic             ex_redirect;
    logic [PC_W-1:0]  ex_target;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             pc_redirect;
    logic [PC_W-1:0]  pc_target;
    logic             busy_wait;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_redir_cnt;

    // Pipeline side
    modport master (
        output if_busy, mem_busy, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_is_load, ex_dst, ex_redirect, ex_target,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               pc_redirect, pc_target, busy_wait, perf_stall_cnt, perf_redir_cnt
    );

    // Hazard controller side
    modport slave (
        input  if_busy, mem_busy, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_is_load, ex_dst, ex_redirect, ex_target,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               pc_redirect, pc_target, busy_wait, perf_stall_cnt, perf_redir_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; controls are combinational (0 cycles) from state+inputs.
// Memory busy freezes the whole pipe; a redirect arriving during an outstanding fetch is deferred until it returns.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 64
) (
    input  logic             clk,
    input  logic             reset,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [0:0] {RUN, WAIT_FETCH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pend_pc;
    logic [PC_W-1:0]  pend_nxt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redir_cnt;
    logic             redir_inc;
    logic             load_use;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_w;
    logic             pc_redirect;
    logic [PC_W-1:0]  pc_target;

    // A load writing x0 produces nothing to wait for.
    assign load_use = bus.ex_valid && bus.ex_is_load && (bus.ex_dst != 5'd0) && bus.id_valid &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_dst)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_dst)));

    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        stall_m     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        flush_w     = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        redir_inc   = 1'b0;
        state_nxt   = state;
        pend_nxt    = pend_pc;

        if (reset) begin
            state_nxt = RUN;
        end else if (bus.mem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (state == RUN) begin
            if (bus.ex_redirect) begin
                flush_d   = 1'b1;
                flush_e   = 1'b1;
                redir_inc = 1'b1;
                if (bus.if_busy) begin
                    // Wrong-path fetch still in flight: park the target until it returns.
                    stall_f   = 1'b1;
                    pend_nxt  = bus.ex_target;
                    state_nxt = WAIT_FETCH;
                end else begin
                    pc_redirect = 1'b1;
                    pc_target   = bus.ex_target;
                end
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (bus.if_busy) begin
                stall_f = 1'b1;
                flush_d = 1'b1;
            end
        end else begin
            flush_d = 1'b1;
            if (bus.if_busy) begin
                stall_f = 1'b1;
                if (bus.ex_redirect) begin
                    pend_nxt  = bus.ex_target;
                    redir_inc = 1'b1;
                end
            end else begin
                pc_redirect = 1'b1;
                pc_target   = pend_pc;
                state_nxt   = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pend_pc   <= '0;
            stall_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pend_pc   <= pend_nxt;
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, stall_f};
            redir_cnt <= redir_cnt + {{(CNT_W-1){1'b0}}, redir_inc};
        end
    end

    assign bus.stall_f        = stall_f;
    assign bus.stall_d        = stall_d;
    assign bus.stall_e        = stall_e;
    assign bus.stall_m        = stall_m;
    assign bus.flush_d        = flush_d;
    assign bus.flush_e        = flush_e;
    assign bus.flush_w        = flush_w;
    assign bus.pc_redirect    = pc_redirect;
    assign bus.pc_target      = pc_target;
    assign bus.busy_wait      = !reset && (state == WAIT_FETCH);
    assign bus.perf_stall_cnt = reset ? '0 : stall_cnt;
    assign bus.perf_redir_cnt = reset ? '0 : redir_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; narrow counters make the wrap reachable quickly.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int PC_W  = 64;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_redir;
    logic [8:0]       ov;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W), .PC_W(PC_W)) bus ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, pc_redirect, busy_wait}
    assign ov = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m, bus.flush_d,
                 bus.flush_e, bus.flush_w, bus.pc_redirect, bus.busy_wait};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.if_busy     = 1'b0;
        bus.mem_busy    = 1'b0;
        bus.id_valid    = 1'b0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_use_rs1  = 1'b0;
        bus.id_use_rs2  = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_dst      = 5'd0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = '0;
    endtask

    task automatic redirect(input logic [PC_W-1:0] tgt, input logic busy);
        idle();
        bus.ex_redirect = 1'b1;
        bus.ex_target   = tgt;
        bus.if_busy     = busy;
    endtask

    task automatic load(input logic [4:0] dst, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
        idle();
        bus.ex_valid   = 1'b1;
        bus.ex_is_load = 1'b1;
        bus.ex_dst     = dst;
        bus.id_valid   = 1'b1;
        bus.id_rs1     = rs1;
        bus.id_use_rs1 = u1;
        bus.id_rs2     = rs2;
        bus.id_use_rs2 = u2;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        exp_stall = '0;
        exp_redir = '0;

        // Reset held: outputs forced low even with every request active
        reset = 1'b1;
        idle();
        bus.mem_busy    = 1'b1;
        bus.if_busy     = 1'b1;
        bus.ex_redirect = 1'b1;
        bus.ex_target   = 64'hdead;
        #2;
        chk("reset_ctl", ov, 9'b0);
        chk("reset_tgt", bus.pc_target, 64'h0);
        chk("reset_scnt", bus.perf_stall_cnt, 4'h0);
        chk("reset_rcnt", bus.perf_redir_cnt, 4'h0);

        @(negedge clk); reset = 1'b0; idle(); #1;
        chk("idle_ctl", ov, 9'b0);

        // Load-use via rs2, via rs1, and a matching but unused rs1
        @(negedge clk); load(5'd5, 5'd3, 1'b1, 5'd5, 1'b1); #1;
        chk("lu_rs2_ctl", ov, 9'b110001000);
        exp_stall++;
        @(negedge clk); idle(); #1;
        chk("lu_after_ctl", ov, 9'b0);
        chk("lu_scnt", bus.perf_stall_cnt, exp_stall);
        @(negedge clk); load(5'd7, 5'd7, 1'b1, 5'd9, 1'b0); #1;
        chk("lu_rs1_ctl", ov, 9'b110001000);
        exp_stall++;
        @(negedge clk); load(5'd7, 5'd7, 1'b0, 5'd9, 1'b1); #1;
        chk("lu_unused_ctl", ov, 9'b0);

        // Redirect with fetch idle
        @(negedge clk); redirect(64'h8000_0100, 1'b0); #1;
        chk("redir_ctl", ov, 9'b000011010);
        chk("redir_tgt", bus.pc_target, 64'h8000_0100);
        exp_redir++;
        @(negedge clk); idle(); #1;
        chk("redir_after_ctl", ov, 9'b0);
        chk("redir_rcnt", bus.perf_redir_cnt, exp_redir);

        // Deferred redirect behind an outstanding fetch
        @(negedge clk); redirect(64'h8000_0200, 1'b1); #1;
        chk("defer_accept_ctl", ov, 9'b100011000);
        chk("defer_accept_tgt", bus.pc_target, 64'h0);
        exp_stall++;
        exp_redir++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); bus.if_busy = 1'b1; #1;
            chk("defer_wait_ctl", ov, 9'b100010001);
            exp_stall++;
        end
        @(negedge clk); idle(); #1;
        chk("defer_release_ctl", ov, 9'b000010011);
        chk("defer_release_tgt", bus.pc_target, 64'h8000_0200);
        @(negedge clk); idle(); #1;
        chk("defer_done_ctl", ov, 9'b0);
        chk("defer_rcnt", bus.perf_redir_cnt, exp_redir);
        chk("defer_scnt", bus.perf_stall_cnt, exp_stall);

        // Newer redirect while waiting replaces the parked target
        @(negedge clk); redirect(64'hA000, 1'b1); #1;
        exp_stall++;
        exp_redir++;
        @(negedge clk); redirect(64'hB000, 1'b1); #1;
        chk("ovr_wait_ctl", ov, 9'b100010001);
        exp_stall++;
        exp_redir++;
        @(negedge clk); idle(); #1;
        chk("ovr_release_ctl", ov, 9'b000010011);
        chk("ovr_release_tgt", bus.pc_target, 64'hB000);
        @(negedge clk); idle(); #1;
        chk("ovr_rcnt", bus.perf_redir_cnt, exp_redir);

        // Memory freeze masks a pending redirect, which is then taken once
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); redirect(64'h8000_0400, 1'b0); bus.mem_busy = 1'b1; #1;
            chk("mem_ctl", ov, 9'b111100100);
            chk("mem_tgt", bus.pc_target, 64'h0);
            exp_stall++;
        end
        @(negedge clk); redirect(64'h8000_0400, 1'b0); #1;
        chk("mem_release_ctl", ov, 9'b000011010);
        chk("mem_release_tgt", bus.pc_target, 64'h8000_0400);
        exp_redir++;
        @(negedge clk); idle(); #1;
        chk("mem_rcnt", bus.perf_redir_cnt, exp_redir);
        chk("mem_scnt", bus.perf_stall_cnt, exp_stall);

        // Reset while parked in WAIT_FETCH
        @(negedge clk); redirect(64'h1234, 1'b1); #1;
        exp_stall++;
        exp_redir++;
        @(negedge clk); idle(); bus.if_busy = 1'b1; #1;
        chk("rstw_wait_ctl", ov, 9'b100010001);
        chk("rstw_pre_scnt", bus.perf_stall_cnt, exp_stall);
        #2 reset = 1'b1;
        #1;
        chk("rstw_async_ctl", ov, 9'b0);
        chk("rstw_scnt", bus.perf_stall_cnt, 4'h0);
        chk("rstw_rcnt", bus.perf_redir_cnt, 4'h0);
        reset = 1'b0;
        exp_stall = 4'd1;
        exp_redir = 4'd0;
        @(negedge clk); idle(); #1;
        chk("rstw_fall_ctl", ov, 9'b0);
        chk("rstw_fall_tgt", bus.pc_target, 64'h0);
        chk("rstw_post_scnt", bus.perf_stall_cnt, exp_stall);

        // Load to x0 is not a hazard
        @(negedge clk); load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); #1;
        chk("x0_ctl", ov, 9'b0);
        @(negedge clk); idle(); #1;
        chk("x0_scnt", bus.perf_stall_cnt, exp_stall);

        // Drive the stall counter to all-ones, then one more stall wraps it
        for (int i = 0; i < 14; i++) begin
            @(negedge clk); idle(); bus.if_busy = 1'b1; #1;
            exp_stall++;
        end
        @(negedge clk); idle(); #1;
        chk("wrap_full", bus.perf_stall_cnt, 4'hF);
        @(negedge clk); idle(); bus.if_busy = 1'b1; #1;
        chk("wrap_stall_ctl", ov, 9'b100010000);
        @(negedge clk); idle(); #1;
        chk("wrap_zero", bus.perf_stall_cnt, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
